id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection and WB->ID bypass.

---
 rtl/id_ex_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB->ID bypass on capture,
// WB refresh of held operands, and a saturating load-use bubble counter.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic [4:0]        i_id_rd,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [CTRL_W-1:0] i_id_ctrl,
    input  logic              i_id_mem_read,
    input  logic              i_id_reg_write,
    input  logic [4:0]        i_wb_rd,
    input  logic              i_wb_reg_write,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_flush,
    input  logic              i_ex_hold,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_ex_pc,
    output logic [XLEN-1:0]   o_ex_imm,
    output logic [XLEN-1:0]   o_ex_rs1_data,
    output logic [XLEN-1:0]   o_ex_rs2_data,
    output logic [4:0]        o_ex_rs1,
    output logic [4:0]        o_ex_rs2,
    output logic [4:0]        o_ex_rd,
    output logic [CTRL_W-1:0] o_ex_ctrl,
    output logic              o_ex_mem_read,
    output logic              o_ex_reg_write,
    output logic              o_stall_id,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [4:0]        rs1_q, rs1_d;
    logic [4:0]        rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              mem_read_q, mem_read_d;
    logic              reg_write_q, reg_write_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic hazard;
    logic wb_active;
    logic wb_hit_id_rs1, wb_hit_id_rs2;
    logic wb_hit_ex_rs1, wb_hit_ex_rs2;

    assign hazard = valid_q & mem_read_q & (rd_q != 5'd0) & i_id_valid &
                    ((i_id_uses_rs1 & (i_id_rs1 == rd_q)) |
                     (i_id_uses_rs2 & (i_id_rs2 == rd_q)));

    assign wb_active     = i_wb_reg_write & (i_wb_rd != 5'd0);
    assign wb_hit_id_rs1 = wb_active & (i_wb_rd == i_id_rs1);
    assign wb_hit_id_rs2 = wb_active & (i_wb_rd == i_id_rs2);
    assign wb_hit_ex_rs1 = wb_active & valid_q & (i_wb_rd == rs1_q);
    assign wb_hit_ex_rs2 = wb_active & valid_q & (i_wb_rd == rs2_q);

    // A flush kills the ID instruction, so a coincident hazard must not stall IF/ID.
    assign o_stall_id = i_ex_hold | (hazard & ~i_flush);

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        cnt_d       = cnt_q;

        if (i_ex_hold) begin
            if (wb_hit_ex_rs1) rs1_data_d = i_wb_data;
            if (wb_hit_ex_rs2) rs2_data_d = i_wb_data;
        end else if (i_flush || hazard) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            imm_d       = '0;
            rs1_data_d  = '0;
            rs2_data_d  = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            ctrl_d      = '0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            if (!i_flush && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end else begin
            valid_d     = i_id_valid;
            pc_d        = i_id_pc;
            imm_d       = i_id_imm;
            rs1_data_d  = wb_hit_id_rs1 ? i_wb_data : i_id_rs1_data;
            rs2_data_d  = wb_hit_id_rs2 ? i_wb_data : i_id_rs2_data;
            rs1_d       = i_id_rs1;
            rs2_d       = i_id_rs2;
            rd_d        = i_id_rd;
            ctrl_d      = i_id_ctrl;
            mem_read_d  = i_id_mem_read;
            reg_write_d = i_id_reg_write & i_id_valid & (i_id_rd != 5'd0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_ex_valid     = valid_q;
    assign o_ex_pc        = pc_q;
    assign o_ex_imm       = imm_q;
    assign o_ex_rs1_data  = rs1_data_q;
    assign o_ex_rs2_data  = rs2_data_q;
    assign o_ex_rs1       = rs1_q;
    assign o_ex_rs2       = rs2_q;
    assign o_ex_rd        = rd_q;
    assign o_ex_ctrl      = ctrl_q;
    assign o_ex_mem_read  = mem_read_q;
    assign o_ex_reg_write = reg_write_q;
    assign o_bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/hold/bypass/reset cases
// followed by randomized traffic, all compared against a behavioural EX-slot model.
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;   // narrow counter so saturation is reachable quickly

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_id_valid;
    logic [XLEN-1:0]   i_id_pc;
    logic [4:0]        i_id_rs1, i_id_rs2, i_id_rd;
    logic              i_id_uses_rs1, i_id_uses_rs2;
    logic [XLEN-1:0]   i_id_rs1_data, i_id_rs2_data, i_id_imm;
    logic [CTRL_W-1:0] i_id_ctrl;
    logic              i_id_mem_read, i_id_reg_write;
    logic [4:0]        i_wb_rd;
    logic              i_wb_reg_write;
    logic [XLEN-1:0]   i_wb_data;
    logic              i_flush, i_ex_hold;

    logic              o_ex_valid;
    logic [XLEN-1:0]   o_ex_pc, o_ex_imm, o_ex_rs1_data, o_ex_rs2_data;
    logic [4:0]        o_ex_rs1, o_ex_rs2, o_ex_rd;
    logic [CTRL_W-1:0] o_ex_ctrl;
    logic              o_ex_mem_read, o_ex_reg_write, o_stall_id;
    logic [CNT_W-1:0]  o_bubble_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_valid(i_id_valid), .i_id_pc(i_id_pc),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
        .i_id_uses_rs1(i_id_uses_rs1), .i_id_uses_rs2(i_id_uses_rs2),
        .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
        .i_id_imm(i_id_imm), .i_id_ctrl(i_id_ctrl),
        .i_id_mem_read(i_id_mem_read), .i_id_reg_write(i_id_reg_write),
        .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_ex_hold(i_ex_hold),
        .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_imm(o_ex_imm),
        .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data),
        .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
        .o_ex_ctrl(o_ex_ctrl), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_reg_write(o_ex_reg_write), .o_stall_id(o_stall_id),
        .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic              valid;
        logic [XLEN-1:0]   pc, imm, d1, d2;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic              mr, rw;
        int                bubbles;
    } ex_t;

    ex_t m;
    int  n_pass = 0;
    int  n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // The ID instruction depends on a load now sitting in EX whose result is not ready yet.
    function automatic bit model_hazard();
        bit reads_rd;
        reads_rd = (i_id_uses_rs1 && i_id_rs1 == m.rd) || (i_id_uses_rs2 && i_id_rs2 == m.rd);
        return m.valid && m.mr && (m.rd != 0) && i_id_valid && reads_rd;
    endfunction

    function automatic bit wb_writes(input logic [4:0] idx);
        return i_wb_reg_write && (i_wb_rd != 0) && (i_wb_rd == idx);
    endfunction

    task automatic model_clock();
        int saved;
        bit haz;
        haz = model_hazard();
        if (!i_rst_n) begin
            m = '{default: 0};
        end else if (i_ex_hold) begin
            if (m.valid && wb_writes(m.rs1)) m.d1 = i_wb_data;
            if (m.valid && wb_writes(m.rs2)) m.d2 = i_wb_data;
        end else if (i_flush || haz) begin
            saved = m.bubbles;
            m = '{default: 0};
            m.bubbles = (!i_flush && saved < (1 << CNT_W) - 1) ? saved + 1 : saved;
        end else begin
            m.valid = i_id_valid;
            m.pc    = i_id_pc;
            m.imm   = i_id_imm;
            m.d1    = wb_writes(i_id_rs1) ? i_wb_data : i_id_rs1_data;
            m.d2    = wb_writes(i_id_rs2) ? i_wb_data : i_id_rs2_data;
            m.rs1   = i_id_rs1;
            m.rs2   = i_id_rs2;
            m.rd    = i_id_rd;
            m.ctrl  = i_id_ctrl;
            m.mr    = i_id_mem_read;
            m.rw    = i_id_reg_write && i_id_valid && (i_id_rd != 0);
        end
    endtask

    task automatic check_all();
        chk("valid",     64'(o_ex_valid),     64'(m.valid));
        chk("pc",        64'(o_ex_pc),        64'(m.pc));
        chk("imm",       64'(o_ex_imm),       64'(m.imm));
        chk("rs1_data",  64'(o_ex_rs1_data),  64'(m.d1));
        chk("rs2_data",  64'(o_ex_rs2_data),  64'(m.d2));
        chk("rs1",       64'(o_ex_rs1),       64'(m.rs1));
        chk("rs2",       64'(o_ex_rs2),       64'(m.rs2));
        chk("rd",        64'(o_ex_rd),        64'(m.rd));
        chk("ctrl",      64'(o_ex_ctrl),      64'(m.ctrl));
        chk("mem_read",  64'(o_ex_mem_read),  64'(m.mr));
        chk("reg_write", 64'(o_ex_reg_write), 64'(m.rw));
        chk("bubbles",   64'(o_bubble_cnt),   64'(m.bubbles));
        chk("stall",     64'(o_stall_id),
            64'(i_ex_hold || (model_hazard() && !i_flush)));
    endtask

    // Inputs are driven after a negedge; check before the edge, then advance the model.
    task automatic cycle();
        #1;
        check_all();
        @(posedge i_clk);
        model_clock();
        @(negedge i_clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic mr, input logic rw);
        i_id_valid     = v;
        i_id_rs1       = r1;
        i_id_rs2       = r2;
        i_id_rd        = rd;
        i_id_uses_rs1  = u1;
        i_id_uses_rs2  = u2;
        i_id_mem_read  = mr;
        i_id_reg_write = rw;
        i_id_pc        = $urandom;
        i_id_imm       = $urandom;
        i_id_rs1_data  = $urandom;
        i_id_rs2_data  = $urandom;
        i_id_ctrl      = CTRL_W'($urandom);
    endtask

    task automatic idle_ctl();
        i_rst_n        = 1'b1;
        i_flush        = 1'b0;
        i_ex_hold      = 1'b0;
        i_wb_reg_write = 1'b0;
        i_wb_rd        = 5'd0;
        i_wb_data      = '0;
    endtask

    task automatic load_use_pair();
        set_id(1, 0, 0, 5, 0, 0, 1, 1);
        cycle();
        set_id(1, 5, 1, 6, 1, 1, 0, 1);
        cycle();
        cycle();
    endtask

    initial begin
        idle_ctl();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        m = '{default: 0};
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // reset state
        cycle();

        // lw x5; add x6,x5,x1 -> one bubble then add enters
        set_id(1, 0, 0, 5, 0, 0, 1, 1);
        cycle();
        set_id(1, 5, 1, 6, 1, 1, 0, 1);
        #1 chk("lu_stall", 64'(o_stall_id), 64'd1);
        cycle();
        chk("lu_bubble_valid", 64'(o_ex_valid), 64'd0);
        chk("lu_cnt", 64'(o_bubble_cnt), 64'd1);
        cycle();
        chk("lu_add_valid", 64'(o_ex_valid), 64'd1);
        chk("lu_add_rd", 64'(o_ex_rd), 64'd6);

        // lw x0 then reader of x0: no stall
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        cycle();
        set_id(1, 0, 1, 6, 1, 1, 0, 1);
        #1 chk("x0_no_stall", 64'(o_stall_id), 64'd0);
        cycle();

        // lw x5 then instruction with rs2=5 but uses_rs2=0
        set_id(1, 0, 0, 5, 0, 0, 1, 1);
        cycle();
        set_id(1, 1, 5, 6, 1, 0, 0, 1);
        #1 chk("unused_rs2_no_stall", 64'(o_stall_id), 64'd0);
        cycle();

        // hazard coincident with flush
        set_id(1, 0, 0, 5, 0, 0, 1, 1);
        cycle();
        set_id(1, 5, 1, 6, 1, 1, 0, 1);
        i_flush = 1'b1;
        #1 chk("flush_stall", 64'(o_stall_id), 64'd0);
        cycle();
        i_flush = 1'b0;
        chk("flush_valid", 64'(o_ex_valid), 64'd0);
        chk("flush_cnt", 64'(o_bubble_cnt), 64'd1);

        // hold for 3 cycles while WB writes x7
        set_id(1, 7, 2, 8, 1, 1, 0, 1);
        cycle();
        i_ex_hold      = 1'b1;
        i_wb_reg_write = 1'b1;
        i_wb_rd        = 5'd7;
        i_wb_data      = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 1, 1);
            cycle();
        end
        idle_ctl();
        chk("hold_rs1_data", 64'(o_ex_rs1_data), 64'hDEAD_BEEF);
        chk("hold_rd", 64'(o_ex_rd), 64'd8);
        chk("hold_valid", 64'(o_ex_valid), 64'd1);

        // WB bypass into both operands on capture
        i_wb_reg_write = 1'b1;
        i_wb_rd        = 5'd3;
        i_wb_data      = 32'h0000_1234;
        set_id(1, 3, 3, 9, 1, 1, 0, 1);
        cycle();
        idle_ctl();
        chk("byp_rs1", 64'(o_ex_rs1_data), 64'h1234);
        chk("byp_rs2", 64'(o_ex_rs2_data), 64'h1234);

        // reset mid-stream with valid EX contents
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        i_rst_n = 1'b0;
        cycle();
        i_rst_n = 1'b1;
        chk("rst_valid", 64'(o_ex_valid), 64'd0);
        chk("rst_pc", 64'(o_ex_pc), 64'd0);
        chk("rst_cnt", 64'(o_bubble_cnt), 64'd0);
        chk("rst_stall", 64'(o_stall_id), 64'd0);

        // counter saturation
        for (int k = 0; k < (1 << CNT_W) + 2; k++) load_use_pair();
        chk("sat_cnt", 64'(o_bubble_cnt), 64'((1 << CNT_W) - 1));
        set_id(1, 0, 0, 5, 0, 0, 1, 1);
        cycle();
        set_id(1, 5, 5, 6, 0, 1, 0, 1);
        cycle();
        chk("sat_hold", 64'(o_bubble_cnt), 64'((1 << CNT_W) - 1));

        // randomized traffic, small register set to provoke matches
        for (int k = 0; k < 800; k++) begin
            i_rst_n        = ($urandom_range(0, 99) >= 2);
            i_flush        = ($urandom_range(0, 99) < 10);
            i_ex_hold      = ($urandom_range(0, 99) < 15);
            i_wb_reg_write = $urandom_range(0, 1) == 1;
            i_wb_rd        = 5'($urandom_range(0, 7));
            i_wb_data      = $urandom;
            set_id($urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            cycle();
        end
        idle_ctl();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
